// File: rtl/stereo_demux.sv
// Stereo MPX receive path: removes the regenerated pilot from each sample, then
// pairs the alternating R/L stream into aligned stereo samples with error counters.
module stereo_demux #(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mpx_in,
    input  logic        mpx_valid,
    input  logic [15:0] pilot_in,
    input  logic        resync,
    input  logic        cnt_clr,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    output logic        phase,
    output logic [15:0] sat_count,
    output logic [15:0] drop_count
);

    typedef enum logic {
        WAIT_R = 1'b0,
        WAIT_L = 1'b1
    } pair_state_t;

    // Gap counter value at which the held R sample is abandoned.
    localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // ------------------------------------------------------------------
    // Stage 1: pilot subtraction with clamp
    // ------------------------------------------------------------------
    logic signed [16:0] w_diff;
    logic               w_clip;
    logic [15:0]        w_s1_data_d;

    logic [15:0]        r_s1_data;
    logic               r_s1_valid;
    logic               r_s1_sat;

    assign w_diff      = $signed({mpx_in[15], mpx_in}) - $signed({pilot_in[15], pilot_in});
    assign w_clip      = w_diff[16] ^ w_diff[15];
    assign w_s1_data_d = w_clip ? (w_diff[16] ? 16'h8000 : 16'h7FFF) : w_diff[15:0];

    // A sample arriving together with resync is thrown away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_data  <= 16'd0;
            r_s1_valid <= 1'b0;
            r_s1_sat   <= 1'b0;
        end else begin
            r_s1_valid <= mpx_valid & ~resync;
            r_s1_sat   <= mpx_valid & ~resync & w_clip;
            if (mpx_valid) begin
                r_s1_data <= w_s1_data_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: R/L pairing FSM
    // ------------------------------------------------------------------
    pair_state_t r_state;
    pair_state_t w_state_next;
    logic [15:0] r_hold;
    logic [15:0] w_hold_next;
    logic [15:0] r_gap;
    logic [15:0] w_gap_next;
    logic [15:0] r_out_l;
    logic [15:0] w_out_l_next;
    logic [15:0] r_out_r;
    logic [15:0] w_out_r_next;
    logic        r_out_valid;
    logic        w_out_valid_next;
    logic        w_drop_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= WAIT_R;
            r_hold      <= 16'd0;
            r_gap       <= 16'd0;
            r_out_l     <= 16'd0;
            r_out_r     <= 16'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold      <= w_hold_next;
            r_gap       <= w_gap_next;
            r_out_l     <= w_out_l_next;
            r_out_r     <= w_out_r_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    // Priority: resync, then gap timeout, then normal sample handling.
    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold;
        w_gap_next       = r_gap;
        w_out_l_next     = r_out_l;
        w_out_r_next     = r_out_r;
        w_out_valid_next = 1'b0;
        w_drop_inc       = 1'b0;

        if (resync) begin
            w_state_next = WAIT_R;
            w_gap_next   = 16'd0;
            w_drop_inc   = (r_state == WAIT_L);
        end else if ((r_state == WAIT_L) && (r_gap == GAP_LAST)) begin
            // A sample landing in the timeout cycle starts a fresh pair.
            w_drop_inc = 1'b1;
            w_gap_next = 16'd0;
            if (r_s1_valid) begin
                w_hold_next  = r_s1_data;
                w_state_next = WAIT_L;
            end else begin
                w_state_next = WAIT_R;
            end
        end else if (r_state == WAIT_R) begin
            if (r_s1_valid) begin
                w_hold_next  = r_s1_data;
                w_gap_next   = 16'd0;
                w_state_next = WAIT_L;
            end
        end else begin
            if (r_s1_valid) begin
                w_out_r_next     = r_hold;
                w_out_l_next     = r_s1_data;
                w_out_valid_next = 1'b1;
                w_state_next     = WAIT_R;
            end else begin
                w_gap_next = r_gap + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counters: saturate at all-ones, clear wins over increment
    // ------------------------------------------------------------------
    logic [15:0] r_sat_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_count  <= 16'd0;
            r_drop_count <= 16'd0;
        end else if (cnt_clr) begin
            r_sat_count  <= 16'd0;
            r_drop_count <= 16'd0;
        end else begin
            if (r_s1_sat && (r_sat_count != CNT_MAX)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
            if (w_drop_inc && (r_drop_count != CNT_MAX)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign out_l      = r_out_l;
    assign out_r      = r_out_r;
    assign out_valid  = r_out_valid;
    assign phase      = (r_state == WAIT_L);
    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_stereo_demux.sv
// Bench for stereo_demux: directed test-plan steps followed by random traffic,
// all checked cycle by cycle against a sample-level reference model.
module tb_stereo_demux;

    localparam int G = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mpx_in;
    logic        mpx_valid;
    logic [15:0] pilot_in;
    logic        resync;
    logic        cnt_clr;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_valid;
    logic        phase;
    logic [15:0] sat_count;
    logic [15:0] drop_count;

    stereo_demux #(.GAP_TIMEOUT(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .mpx_in    (mpx_in),
        .mpx_valid (mpx_valid),
        .pilot_in  (pilot_in),
        .resync    (resync),
        .cnt_clr   (cnt_clr),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .phase     (phase),
        .sat_count (sat_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a sample accepted at one edge is seen by the pairer at
    // the next edge; the pairer holds at most one unmatched R sample.
    bit          p_valid;
    logic [15:0] p_val;
    bit          p_sat;
    bit          m_have_r;
    logic [15:0] m_r;
    int          m_idle;
    logic [15:0] e_l;
    logic [15:0] e_r;
    bit          e_valid;
    int          e_sat;
    int          e_drop;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        p_valid  = 0; p_val = 16'd0; p_sat = 0;
        m_have_r = 0; m_r = 16'd0; m_idle = 0;
        e_l = 16'd0; e_r = 16'd0; e_valid = 0; e_sat = 0; e_drop = 0;
    endtask

    task automatic check_all();
        chk("out_valid",  {15'd0, out_valid}, {15'd0, e_valid});
        chk("out_l",      out_l, e_l);
        chk("out_r",      out_r, e_r);
        chk("phase",      {15'd0, phase}, {15'd0, m_have_r});
        chk("sat_count",  sat_count, 16'(e_sat));
        chk("drop_count", drop_count, 16'(e_drop));
    endtask

    // Advance model by one clock using the inputs currently applied, then
    // let the DUT take the edge and optionally compare.
    task automatic tick(input bit do_chk);
        int d;
        bit drop;
        logic signed [15:0] a;
        logic signed [15:0] b;
        drop    = 0;
        e_valid = 0;
        if (resync) begin
            drop     = m_have_r;
            m_have_r = 0;
            m_idle   = 0;
        end else if (m_have_r && m_idle == G - 1) begin
            drop   = 1;
            m_idle = 0;
            if (p_valid) m_r = p_val;
            else         m_have_r = 0;
        end else if (!m_have_r) begin
            if (p_valid) begin
                m_have_r = 1;
                m_r      = p_val;
                m_idle   = 0;
            end
        end else if (p_valid) begin
            e_l      = p_val;
            e_r      = m_r;
            e_valid  = 1;
            m_have_r = 0;
        end else begin
            m_idle++;
        end
        if (cnt_clr) begin
            e_sat  = 0;
            e_drop = 0;
        end else begin
            if (p_sat && e_sat < 65535)  e_sat++;
            if (drop && e_drop < 65535)  e_drop++;
        end
        a = mpx_in;
        b = pilot_in;
        d = int'(a) - int'(b);
        p_valid = mpx_valid && !resync;
        p_sat   = p_valid && (d > 32767 || d < -32768);
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        p_val = 16'(d);
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic step(input bit v, input logic [15:0] m, input logic [15:0] p,
                        input bit rs, input bit clr, input bit do_chk);
        mpx_valid = v;
        mpx_in    = m;
        pilot_in  = p;
        resync    = rs;
        cnt_clr   = clr;
        tick(do_chk);
    endtask

    task automatic idle();
        step(0, 16'd0, 16'd0, 0, 0, 1);
    endtask

    // Reset is asserted and released mid-cycle, away from the clock edge.
    task automatic apply_reset();
        mpx_valid = 0; mpx_in = 0; pilot_in = 0; resync = 0; cnt_clr = 0;
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        check_all();
    endtask

    initial begin
        bit saw_valid;
        int lo_rate;
        reset = 1; mpx_valid = 0; mpx_in = 0; pilot_in = 0; resync = 0; cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_phase", {15'd0, phase}, 16'd0);
        reset = 0;

        // Pairing: pairs emerge after the 3rd and 5th edges.
        step(1, 16'h0100, 16'h0000, 0, 0, 1);
        step(1, 16'h0200, 16'h0000, 0, 0, 1);
        step(1, 16'h0300, 16'h0000, 0, 0, 1);
        chk("pair1_valid", {15'd0, out_valid}, 16'd1);
        chk("pair1_l", out_l, 16'h0200);
        chk("pair1_r", out_r, 16'h0100);
        step(1, 16'h0400, 16'h0000, 0, 0, 1);
        chk("pair_gap_valid", {15'd0, out_valid}, 16'd0);
        idle();
        chk("pair2_valid", {15'd0, out_valid}, 16'd1);
        chk("pair2_l", out_l, 16'h0400);
        chk("pair2_r", out_r, 16'h0300);

        // Pilot removal with clamp.
        apply_reset();
        step(1, 16'h7F00, 16'hFE00, 0, 0, 1);
        step(1, 16'h1234, 16'h0034, 0, 0, 1);
        idle();
        chk("sat_r", out_r, 16'h7FFF);
        chk("sat_l", out_l, 16'h1200);
        chk("sat_cnt1", sat_count, 16'd1);

        // Timeout after a lone R, then a clean pair.
        apply_reset();
        step(1, 16'h1111, 16'h0000, 0, 0, 1);
        repeat (20) idle();
        chk("to_drop", drop_count, 16'd1);
        chk("to_phase", {15'd0, phase}, 16'd0);
        step(1, 16'h2222, 16'h0000, 0, 0, 1);
        step(1, 16'h3333, 16'h0000, 0, 0, 1);
        idle();
        chk("to_pair_r", out_r, 16'h2222);
        chk("to_pair_l", out_l, 16'h3333);

        // Sample arriving exactly in the timeout cycle becomes the new R.
        apply_reset();
        step(1, 16'h0A0A, 16'h0000, 0, 0, 1);
        repeat (7) idle();
        step(1, 16'h0B0B, 16'h0000, 0, 0, 1);
        idle();
        chk("toedge_drop", drop_count, 16'd1);
        chk("toedge_phase", {15'd0, phase}, 16'd1);
        step(1, 16'h0C0C, 16'h0000, 0, 0, 1);
        idle();
        chk("toedge_r", out_r, 16'h0B0B);
        chk("toedge_l", out_l, 16'h0C0C);

        // Resync while holding R, with a colliding sample.
        apply_reset();
        saw_valid = 0;
        step(1, 16'h0500, 16'h0000, 0, 0, 1);
        idle();
        idle();
        step(1, 16'h0600, 16'h0000, 1, 0, 1);
        saw_valid |= out_valid;
        idle();
        saw_valid |= out_valid;
        chk("rs_drop", drop_count, 16'd1);
        chk("rs_no_valid", {15'd0, saw_valid}, 16'd0);
        step(1, 16'h0700, 16'h0000, 0, 0, 1);
        step(1, 16'h0800, 16'h0000, 0, 0, 1);
        idle();
        chk("rs_pair_r", out_r, 16'h0700);
        chk("rs_pair_l", out_l, 16'h0800);

        // Asynchronous reset while in WAIT_L.
        step(1, 16'h0900, 16'h0000, 0, 0, 1);
        idle();
        chk("ar_phase_pre", {15'd0, phase}, 16'd1);
        #2;
        reset = 1;
        #1;
        chk("ar_l", out_l, 16'd0);
        chk("ar_r", out_r, 16'd0);
        chk("ar_phase", {15'd0, phase}, 16'd0);
        chk("ar_drop", drop_count, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        check_all();

        // Counter saturation and clear (including a lost same-cycle increment).
        for (int i = 0; i < 70000; i++) step(1, 16'h7FFF, 16'h8000, 0, 0, 0);
        idle();
        idle();
        chk("satmax", sat_count, 16'hFFFF);
        step(0, 16'd0, 16'd0, 0, 1, 1);
        chk("satclr", sat_count, 16'd0);
        step(1, 16'h7FFF, 16'h8000, 0, 0, 1);
        step(0, 16'd0, 16'd0, 0, 1, 1);
        chk("satclr_lost", sat_count, 16'd0);
        idle();

        // Random traffic with alternating dense/sparse phases.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            lo_rate = ((i / 200) % 2 == 1) ? 10 : 85;
            step(($urandom_range(99) < lo_rate),
                 16'($urandom),
                 ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(255)),
                 ($urandom_range(99) < 2),
                 ($urandom_range(99) < 1),
                 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stereo_demux.md
# stereo_demux

Receive-side counterpart to the stereo MPX encoder. Takes the time-multiplexed MPX sample stream (alternating R, L, R, L… with a scaled pilot tone added to every sample), subtracts a locally regenerated pilot, and reassembles the samples into aligned L/R pairs. It sits between the MPX source (demodulator or loopback from the encoder) and the audio sink, and exposes error counters for the register block.

## Interface
- `GAP_TIMEOUT`, 1024: idle cycles allowed in WAIT_L before a held R sample is dropped (range 2..65535).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `mpx_in` in 16: signed two's-complement MPX sample.
- `mpx_valid` in 1: `mpx_in`/`pilot_in` valid this cycle.
- `pilot_in` in 16: signed local pilot estimate, sampled with `mpx_valid`.
- `resync` in 1: one-cycle pulse; forces phase back to expect R.
- `cnt_clr` in 1: clears `sat_count` and `drop_count`.
- `out_l` out 16: recovered left sample, signed.
- `out_r` out 16: recovered right sample, signed.
- `out_valid` out 1: one-cycle pulse, pair valid.
- `phase` out 1: 0 = WAIT_R, 1 = WAIT_L.
- `sat_count` out 16: saturating count of clipped subtractions.
- `drop_count` out 16: saturating count of discarded R samples.

## Operation
- Stage 1 (subtract): on `mpx_valid`, diff = sext17(`mpx_in`) − sext17(`pilot_in`); result clamped to [−32768, 32767]; registered as s1_data with s1_valid = `mpx_valid`. A clamp sets s1_sat, which increments `sat_count`.
- Stage 2 (pair FSM), acting on s1_valid:
  - WAIT_R: latch s1_data into r_hold → WAIT_L, clear gap counter.
  - WAIT_L: drive `out_r` = r_hold, `out_l` = s1_data, pulse `out_valid` → WAIT_R.
  - WAIT_L without s1_valid: gap counter +1 per cycle; on reaching `GAP_TIMEOUT`, discard r_hold, `drop_count` +1 → WAIT_R.
- Priority per cycle: `resync` > timeout > sample.
- `resync`: next state WAIT_R; s1_valid cleared, so the in-flight stage-1 sample is discarded; a `mpx_valid` in the same cycle as `resync` is also discarded. If the state was WAIT_L, `drop_count` +1. No `out_valid` is produced in the `resync` cycle or the following cycle.
- Counters stick at 0xFFFF. `cnt_clr` zeroes both counters; an increment in the same cycle is lost, and the counter reads 0.
- `out_l`/`out_r` hold their last values between pulses.

## Timing
- Reset: state WAIT_R, `phase` = 0, all outputs 0, s1_valid = 0, r_hold = 0, gap counter = 0.
- Latency: the L sample's `mpx_valid` at cycle n gives `out_valid` at n+2. R at cycle m updates `phase` at m+2.
- Back-to-back `mpx_valid` every cycle is supported; pair throughput is one per two samples.
- No backpressure; the sink must accept every `out_valid`.
- Timeout: the last R arrives in stage 2 at cycle t. With no further samples, `drop_count` increments and `phase` falls to 0 at t+`GAP_TIMEOUT`+1. A sample that reaches stage 2 in the timeout cycle is treated as a new R.
- Reset asserted mid-pair: the held R is lost silently, with no `drop_count` increment.

## Test plan
- Pairing: pilot_in = 0, feed R = 0x0100, L = 0x0200, R = 0x0300, L = 0x0400 on consecutive cycles -> `out_valid` at cycles 3 and 5 with (L, R) = (0x0200, 0x0100) and then (0x0400, 0x0300).
- Pilot removal and saturation: mpx_in = 0x7F00 with pilot_in = −0x0200 gives 0x7FFF and `sat_count` = 1; mpx_in = 0x1234 with pilot_in = 0x0034 gives 0x1200.
- Timeout: GAP_TIMEOUT = 8, send one R then idle 20 cycles -> `drop_count` = 1 and `phase` = 0. The next two samples then form a pair with the first treated as R.
- Resync: send R, then `resync` together with a `mpx_valid` -> `drop_count` = 1, no `out_valid`; the following R/L pair decodes correctly.
- Async reset in WAIT_L: assert `reset` between clock edges -> all outputs 0 immediately, `drop_count` unchanged (0).
- Counter saturation and clear: force 70000 clipped samples -> `sat_count` = 0xFFFF; pulse `cnt_clr` -> 0.
